// File: rtl/astra_pifo_ingress.sv
// -----------------------------------------------------------------------------
// astra_pifo_ingress
//
// Upstream command stage for the Astra PIFO. It buffers {meta, prio} enqueues
// in a first-word-fall-through ingress FIFO and counts outstanding dequeue
// requests. It issues registered one-cycle push/pop pulses to the PIFO only
// while the PIFO is ready. A push and a pop can go out together in one cycle.
// It tracks PIFO occupancy so the PIFO never overflows and is never popped
// while empty. Popped entries come back POP_LAT cycles after the pop pulse and
// are forwarded with a single-cycle valid strobe.
//
// Handshakes: a transfer happens on a rising clock edge where valid (or req)
// and ready are both high. Ready is a function of registered state only and
// never depends on the same-cycle valid. o_deq_valid has no ready: the
// consumer must take the entry in the cycle it is presented.
//
// Optional build macro: ASTRA_PIFO_INGRESS_STATS_EN
//   defined   -> o_stat_push / o_stat_pop count issued pulses (wrap at 2^32)
//   undefined -> both ports tied to 0, no counter flops
//
// Ports
//   i_clk, i_arst_n    clock, asynchronous active-low reset
//   i_enq_valid        enqueue request
//   o_enq_ready        ingress FIFO not full
//   i_enq_data         {meta, prio} to enqueue
//   i_deq_req          dequeue request; one accepted pulse = one entry
//   o_deq_req_ready    pending-pop count below PDEPTH
//   o_deq_valid        popped entry valid (single-cycle strobe)
//   o_deq_data         popped entry
//   o_pifo_push        push pulse to the PIFO
//   o_pifo_push_data   push payload (FIFO head, registered with the pulse)
//   o_pifo_pop         pop pulse to the PIFO
//   i_pifo_pop_data    PIFO pop result, valid POP_LAT cycles after o_pifo_pop
//   i_pifo_ready       PIFO accepts a command this cycle
//   o_occupancy        entries currently held by the PIFO
//   o_stat_push        issued push count (stats build only, else 0)
//   o_stat_pop         issued pop count (stats build only, else 0)
// -----------------------------------------------------------------------------
module astra_pifo_ingress #(
  parameter int PTW     = 16,
  parameter int MTW     = 32,
  parameter int FDEPTH  = 8,
  parameter int PDEPTH  = 4,
  parameter int CAP     = 16,
  parameter int POP_LAT = 1,
  localparam int DW     = MTW + PTW,
  localparam int OCCW   = $clog2(CAP + 1)
) (
  input  logic            i_clk,
  input  logic            i_arst_n,
  input  logic            i_enq_valid,
  output logic            o_enq_ready,
  input  logic [DW-1:0]   i_enq_data,
  input  logic            i_deq_req,
  output logic            o_deq_req_ready,
  output logic            o_deq_valid,
  output logic [DW-1:0]   o_deq_data,
  output logic            o_pifo_push,
  output logic [DW-1:0]   o_pifo_push_data,
  output logic            o_pifo_pop,
  input  logic [DW-1:0]   i_pifo_pop_data,
  input  logic            i_pifo_ready,
  output logic [OCCW-1:0] o_occupancy,
  output logic [31:0]     o_stat_push,
  output logic [31:0]     o_stat_pop
);

  localparam int AW   = $clog2(FDEPTH);
  localparam int PTRW = AW + 1;
  localparam int PW   = $clog2(PDEPTH + 1);

  // Ingress FIFO storage; pointers carry one extra wrap bit so that full and
  // empty are distinguishable when the index bits are equal.
  logic [DW-1:0]    fifo_mem [FDEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;

  logic [PW-1:0]    pend;
  logic [PW-1:0]    pend_next;
  logic [OCCW-1:0]  occ;
  logic [OCCW-1:0]  occ_next;
  logic [POP_LAT-1:0] pop_pipe;

  logic             enq_fire;
  logic             deq_fire;
  logic             can_push;
  logic             can_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign o_enq_ready     = ~fifo_full;
  assign o_deq_req_ready = (pend < PW'(PDEPTH));
  assign o_occupancy     = occ;

  assign enq_fire = i_enq_valid & o_enq_ready;
  assign deq_fire = i_deq_req & o_deq_req_ready;

  // A pop needs something in the PIFO; occ counts pushes already decided, so
  // the first push into an empty PIFO can never be paired with a pop.
  // A push into a full PIFO is allowed only when a pop frees a slot together.
  assign can_pop  = (pend != '0) & (occ != '0) & i_pifo_ready;
  assign can_push = ~fifo_empty & i_pifo_ready &
                    ((occ < OCCW'(CAP)) | can_pop);

  always_comb begin
    pend_next = pend;
    occ_next  = occ;
    case ({deq_fire, can_pop})
      2'b10:   pend_next = pend + PW'(1);
      2'b01:   pend_next = pend - PW'(1);
      default: pend_next = pend;
    endcase
    case ({can_push, can_pop})
      2'b10:   occ_next = occ + OCCW'(1);
      2'b01:   occ_next = occ - OCCW'(1);
      default: occ_next = occ;
    endcase
  end

  // Storage array has no reset; the pointers define which words are live.
  always_ff @(posedge i_clk) begin
    if (enq_fire) begin
      fifo_mem[wr_ptr[AW-1:0]] <= i_enq_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      pend             <= '0;
      occ              <= '0;
      o_pifo_push      <= 1'b0;
      o_pifo_pop       <= 1'b0;
      o_pifo_push_data <= '0;
      pop_pipe         <= '0;
      o_deq_valid      <= 1'b0;
      o_deq_data       <= '0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (can_push) begin
        rd_ptr           <= rd_ptr + PTRW'(1);
        o_pifo_push_data <= fifo_mem[rd_ptr[AW-1:0]];
      end
      pend        <= pend_next;
      occ         <= occ_next;
      o_pifo_push <= can_push;
      o_pifo_pop  <= can_pop;

      // Return path: the pop pulse walks POP_LAT stages, and the last stage
      // marks the cycle in which i_pifo_pop_data carries that pop's result.
      for (int i = POP_LAT - 1; i > 0; i--) begin
        pop_pipe[i] <= pop_pipe[i-1];
      end
      pop_pipe[0] <= o_pifo_pop;
      o_deq_valid <= pop_pipe[POP_LAT-1];
      if (pop_pipe[POP_LAT-1]) begin
        o_deq_data <= i_pifo_pop_data;
      end
    end
  end

`ifdef ASTRA_PIFO_INGRESS_STATS_EN
  logic [31:0] stat_push_q;
  logic [31:0] stat_pop_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      stat_push_q <= '0;
      stat_pop_q  <= '0;
    end else begin
      if (o_pifo_push) begin
        stat_push_q <= stat_push_q + 32'd1;
      end
      if (o_pifo_pop) begin
        stat_pop_q <= stat_pop_q + 32'd1;
      end
    end
  end

  assign o_stat_push = stat_push_q;
  assign o_stat_pop  = stat_pop_q;
`else
  assign o_stat_push = '0;
  assign o_stat_pop  = '0;
`endif

endmodule
